sampler_s_eta: RTL and testbench

Secret-polynomial sampler for the Dilithium key-generation datapath (ExpandS). It stores a 512-bit seed and absorbs seed‖N into a shared external SHAKE256 core. It rejection-samples 4-bit nibbles into coefficients in [-η, η] and emits 256 coefficients, reduced mod q, as SAMPLER_W-wide beats. The gen_s controller instantiates one per lane and sequences N over the s1 and s2 polynomials.

---
 rtl/sampler_s_eta_pkg.sv | 24 ++
 rtl/sampler_s_eta_eta_reject.sv | 33 +++
 rtl/sampler_s_eta.sv | 180 ++++++++++++++++++
 tb/tb_sampler_s_eta.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_s_eta_pkg.sv
// Shared constants, FSM state encoding and eta selection for the ExpandS sampler.
package sampler_s_eta_pkg;

  localparam logic [22:0] Q          = 23'd8380417;
  localparam int          RATE_WORDS = 17;
  localparam int          SEED_WORDS = 8;
  localparam int          COEFFS     = 256;
  localparam int          NIBS       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KRST,
    S_ABSORB,
    S_SQUEEZE,
    S_FINISH
  } state_t;

  // eta=4 only for the level-3 parameter set; levels 2 and 5 use eta=2.
  function automatic logic eta_is4(input logic [2:0] sec_lvl);
    return sec_lvl == 3'd3;
  endfunction

endpackage

// File: rtl/sampler_s_eta_eta_reject.sv
// One-nibble rejection step: accept flag plus the coefficient encoded mod q.
module eta_reject
  import sampler_s_eta_pkg::*;
#(
  parameter int SAMPLE_W = 23
) (
  input  logic [3:0]          nib,
  input  logic                eta4,
  output logic                acc,
  output logic [SAMPLE_W-1:0] coef
);

  logic [3:0]        m;
  logic signed [4:0] v;
  logic [4:0]        neg;

  always_comb begin
    m = nib;
    if (nib >= 4'd10)     m = nib - 4'd10;
    else if (nib >= 4'd5) m = nib - 4'd5;
    if (eta4) begin
      acc = nib < 4'd9;
      v   = 5'sd4 - $signed({1'b0, nib});
    end else begin
      acc = nib < 4'd15;
      v   = 5'sd2 - $signed({1'b0, m});
    end
    neg  = 5'(-v);
    // Negative values wrap to q+v.
    coef = v[4] ? (SAMPLE_W'(Q) - SAMPLE_W'(neg)) : SAMPLE_W'(v[3:0]);
  end

endmodule

// File: rtl/sampler_s_eta.sv
// ExpandS secret sampler: seed load, SHAKE256 absorb of seed||N, nibble
// rejection into [-eta,eta] and SAMPLER_W-wide output beats.
module sampler_s_eta
  import sampler_s_eta_pkg::*;
#(
  parameter int SAMPLER_W = 4,
  parameter int SAMPLE_W  = 23,
  parameter int W         = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          re_sample,
  input  logic [2:0]                    sec_lvl,
  input  logic [15:0]                   N,
  input  logic                          valid_i,
  output logic                          ready_i,
  input  logic [W-1:0]                  seed_i,
  output logic [SAMPLER_W*SAMPLE_W-1:0] samples,
  output logic                          valid_o,
  input  logic                          ready_o,
  output logic                          done,
  input  logic                          keccak_ctrl,
  output logic                          rst_k,
  output logic [63:0]                   din,
  input  logic [63:0]                   dout,
  output logic                          src_ready,
  input  logic                          src_read,
  input  logic                          dst_write,
  output logic                          dst_ready
);

  // Room for a full beat plus one cycle's worth of accepted nibbles.
  localparam int BUF_D = (2*SAMPLER_W >= SAMPLER_W + NIBS) ? 2*SAMPLER_W : SAMPLER_W + NIBS;
  localparam int CW    = $clog2(BUF_D + 1);
  localparam int IW    = $clog2(BUF_D);
  localparam int BEATS = COEFFS / SAMPLER_W;
  localparam int BW    = $clog2(BEATS + 1);

  state_t                              state, state_n;
  logic [4:0]                          wcnt;
  logic [15:0]                         n_q;
  logic                                eta4_q;
  logic [SEED_WORDS-1:0][W-1:0]        seed_q;
  logic [63:0]                         hold_q;
  logic                                hold_vld;
  logic [1:0]                          grp_q;
  logic [BUF_D-1:0][SAMPLE_W-1:0]      cbuf_q, cbuf_n;
  logic [CW-1:0]                       cnt_q, cnt_n, cnt_ap;
  logic [8:0]                          tot_q, tot_n;
  logic [BW-1:0]                       beats_q;
  logic                                pop, proc, last_beat;
  logic [NIBS*4-1:0]                   grp_bits;
  logic [NIBS-1:0]                     acc;
  logic [NIBS-1:0][SAMPLE_W-1:0]       coef;

  assign ready_i   = state == S_LOAD;
  assign rst_k     = keccak_ctrl && state == S_KRST;
  assign src_ready = keccak_ctrl && state == S_ABSORB;
  assign dst_ready = keccak_ctrl && state == S_SQUEEZE && !hold_vld;
  assign valid_o   = state == S_SQUEEZE && cnt_q >= CW'(SAMPLER_W);
  assign done      = state == S_FINISH;
  assign pop       = valid_o && ready_o;
  assign last_beat = pop && beats_q == BW'(BEATS - 1);
  assign cnt_ap    = pop ? cnt_q - CW'(SAMPLER_W) : cnt_q;
  assign proc      = state == S_SQUEEZE && hold_vld && cnt_ap <= CW'(BUF_D - NIBS);
  assign grp_bits  = hold_q[{grp_q, 4'b0000} +: NIBS*4];

  genvar g;
  for (g = 0; g < NIBS; g++) begin : g_lane
    eta_reject #(.SAMPLE_W(SAMPLE_W)) u_rej (
      .nib  (grp_bits[g*4 +: 4]),
      .eta4 (eta4_q),
      .acc  (acc[g]),
      .coef (coef[g])
    );
  end

  for (g = 0; g < SAMPLER_W; g++) begin : g_out
    assign samples[g*SAMPLE_W +: SAMPLE_W] = cbuf_q[g];
  end

  always_comb begin
    din = '0;
    if (state == S_ABSORB) begin
      if (wcnt < 5'(SEED_WORDS))             din = 64'(seed_q[wcnt[2:0]]);
      else if (wcnt == 5'(SEED_WORDS))       din = {40'd0, 8'h1F, n_q};
      else if (wcnt == 5'(RATE_WORDS - 1))   din = {8'h80, 56'd0};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_LOAD;
                 else if (re_sample) state_n = S_KRST;
      S_LOAD:    if (valid_i && wcnt == 5'(SEED_WORDS - 1)) state_n = S_KRST;
      S_KRST:    if (keccak_ctrl) state_n = S_ABSORB;
      S_ABSORB:  if (keccak_ctrl && src_read && wcnt == 5'(RATE_WORDS - 1)) state_n = S_SQUEEZE;
      S_SQUEEZE: if (last_beat) state_n = S_FINISH;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Pop the oldest beat first, then append accepted lanes in nibble order.
  always_comb begin
    cbuf_n = cbuf_q;
    cnt_n  = cnt_q;
    tot_n  = tot_q;
    if (pop) begin
      for (int i = 0; i < BUF_D - SAMPLER_W; i++) cbuf_n[i] = cbuf_q[i + SAMPLER_W];
      for (int i = BUF_D - SAMPLER_W; i < BUF_D; i++) cbuf_n[i] = '0;
      cnt_n = cnt_q - CW'(SAMPLER_W);
    end
    if (proc) begin
      for (int l = 0; l < NIBS; l++) begin
        if (acc[l] && tot_n < 9'(COEFFS)) begin
          cbuf_n[cnt_n[IW-1:0]] = coef[l];
          cnt_n = cnt_n + CW'(1);
          tot_n = tot_n + 9'd1;
        end
      end
    end
    if (state == S_IDLE) begin
      cbuf_n = '0;
      cnt_n  = '0;
      tot_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      n_q      <= '0;
      eta4_q   <= 1'b0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      grp_q    <= '0;
      cbuf_q   <= '0;
      cnt_q    <= '0;
      tot_q    <= '0;
      beats_q  <= '0;
    end else begin
      state  <= state_n;
      cbuf_q <= cbuf_n;
      cnt_q  <= cnt_n;
      tot_q  <= tot_n;
      if (state == S_IDLE && (start || re_sample)) begin
        n_q    <= N;
        eta4_q <= eta_is4(sec_lvl);
      end
      case (state)
        S_LOAD:   if (valid_i) wcnt <= (wcnt == 5'(SEED_WORDS - 1)) ? 5'd0 : wcnt + 5'd1;
        S_ABSORB: if (keccak_ctrl && src_read) wcnt <= wcnt + 5'd1;
        default:  wcnt <= '0;
      endcase
      if (state != S_SQUEEZE) begin
        hold_vld <= 1'b0;
        grp_q    <= '0;
      end else if (dst_ready && dst_write) begin
        hold_q   <= dout;
        hold_vld <= 1'b1;
        grp_q    <= '0;
      end else if (proc) begin
        grp_q <= grp_q + 2'd1;
        if (grp_q == 2'd3) hold_vld <= 1'b0;
      end
      if (state == S_IDLE) beats_q <= '0;
      else if (pop)        beats_q <= beats_q + BW'(1);
    end
  end

  // Seed persists across re_sample runs; it is only rewritten by LOAD.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && valid_i) seed_q[wcnt[2:0]] <= seed_i;
  end

endmodule

// File: tb/tb_sampler_s_eta.sv
// Directed bench for sampler_s_eta; the bench plays the Keccak core with a
// deterministic squeeze stream whose first word is 0xFEDCBA9876543210.
module tb_sampler_s_eta;

  localparam int          SW = 4;
  localparam int          SMW = 23;
  localparam logic [22:0] QM = 23'd8380417;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, re_sample = 1'b0;
  logic [2:0]  sec_lvl = 3'd2;
  logic [15:0] N = 16'd0;
  logic        valid_i = 1'b0;
  logic        ready_i;
  logic [63:0] seed_i = '0;
  logic [SW*SMW-1:0] samples;
  logic        valid_o;
  logic        ready_o;
  logic        done;
  logic        keccak_ctrl = 1'b1;
  logic        rst_k;
  logic [63:0] din, dout;
  logic        src_ready, src_read, dst_write, dst_ready;

  always #5 clk = ~clk;

  sampler_s_eta #(.SAMPLER_W(SW), .SAMPLE_W(SMW), .W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .re_sample(re_sample), .sec_lvl(sec_lvl),
    .N(N), .valid_i(valid_i), .ready_i(ready_i), .seed_i(seed_i), .samples(samples),
    .valid_o(valid_o), .ready_o(ready_o), .done(done), .keccak_ctrl(keccak_ctrl),
    .rst_k(rst_k), .din(din), .dout(dout), .src_ready(src_ready), .src_read(src_read),
    .dst_write(dst_write), .dst_ready(dst_ready)
  );

  int nchk = 0, nerr = 0;
  int salt = 1;
  int k_idx, a_idx;
  logic [63:0] absorbed [17];
  logic [22:0] got [$];
  logic [22:0] exp_c [256];
  logic [63:0] tb_seed [8];
  int done_cnt = 0, ri_seen = 0, stall_viol = 0, kc0_viol = 0;
  int done_base, got_base;
  logic rdy_after, timed_out;
  logic rdy_hold = 1'b0, rdy_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [SW*SMW-1:0] prev_s = '0;

  function automatic logic [63:0] wgen(input int k, input int s);
    logic [63:0] x;
    if (k == 0) return 64'hFEDCBA9876543210;
    x = {32'(s), 32'(k)};
    x = x * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 31);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 27);
    return x;
  endfunction

  assign dout      = wgen(k_idx, salt);
  assign src_read  = src_ready;
  assign dst_write = 1'b1;

  always @(negedge clk)
    ready_o = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);

  // Keccak stand-in and observation monitors.
  always @(posedge clk) begin
    if (rst || rst_k) begin
      k_idx <= 0;
      a_idx <= 0;
    end else begin
      if (dst_write && dst_ready) k_idx <= k_idx + 1;
      if (src_ready && src_read && a_idx < 17) begin
        absorbed[a_idx] <= din;
        a_idx <= a_idx + 1;
      end
    end
    if (valid_o && ready_o)
      for (int k = 0; k < SW; k++) got.push_back(samples[k*SMW +: SMW]);
    if (done) done_cnt <= done_cnt + 1;
    if (ready_i) ri_seen <= ri_seen + 1;
    if (prev_stall && valid_o && samples !== prev_s) stall_viol <= stall_viol + 1;
    if (!keccak_ctrl && (src_ready || dst_ready || rst_k)) kc0_viol <= kc0_viol + 1;
    prev_stall <= valid_o && !ready_o;
    prev_s     <= samples;
  end

  task automatic build_exp(input bit e4, input int s);
    int n, k;
    logic [63:0] w;
    logic [3:0] b;
    int m;
    n = 0; k = 0;
    while (n < 256) begin
      w = wgen(k, s);
      for (int j = 0; j < 16 && n < 256; j++) begin
        b = w[j*4 +: 4];
        if (e4) begin
          if (b < 9) begin
            exp_c[n] = (b <= 4) ? 23'(4 - int'(b)) : QM - 23'(int'(b) - 4);
            n++;
          end
        end else if (b < 15) begin
          m = int'(b) % 5;
          exp_c[n] = (m <= 2) ? 23'(2 - m) : QM - 23'(m - 2);
          n++;
        end
      end
      k++;
    end
  endtask

  task automatic launch(input bit use_start, input logic [15:0] n, input logic [2:0] sl, input int s);
    int cyc;
    salt = s;
    @(negedge clk);
    N = n; sec_lvl = sl; start = use_start; re_sample = !use_start;
    @(negedge clk);
    start = 1'b0; re_sample = 1'b0;
    rdy_after = ready_i;
    done_base = done_cnt;
    got_base  = got.size();
    if (use_start) begin
      for (int i = 0; i < 8; i++) begin
        valid_i = 1'b1; seed_i = tb_seed[i];
        cyc = 0;
        while (!ready_i && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
      end
      valid_i = 1'b0;
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 6000) begin @(negedge clk); cyc++; end
    timed_out = !done;
  endtask

  task automatic check_stream(input string nm);
    int bad = 0, first = -1;
    nchk++;
    if (timed_out !== 1'b0) begin
      nerr++; $display("FAIL %s_timeout: done not seen, got %0d coefs", nm, got.size() - got_base);
    end
    nchk++;
    if (got.size() - got_base !== 256) begin
      nerr++; $display("FAIL %s_count: got %0d coefs want 256", nm, got.size() - got_base);
    end
    for (int i = 0; i < 256 && got_base + i < got.size(); i++)
      if (got[got_base + i] !== exp_c[i]) begin bad++; if (first < 0) first = i; end
    nchk++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL %s_coefs: %0d wrong, first idx %0d got %0d want %0d", nm, bad, first,
               got[got_base + first], exp_c[first]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nchk++;
    if ({valid_o, ready_i, done, rst_k, src_ready, dst_ready} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctl: got %b want 000000", {valid_o, ready_i, done, rst_k, src_ready, dst_ready});
    end
    nchk++;
    if (samples !== '0 || din !== '0) begin
      nerr++; $display("FAIL reset_data: samples %0h din %0h want 0", samples, din);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_eta2_zero();
    logic bad_set;
    logic [63:0] orw;
    for (int i = 0; i < 8; i++) tb_seed[i] = '0;
    build_exp(1'b0, 1);
    launch(1'b1, 16'd0, 3'd2, 1);
    nchk++;
    if (rdy_after !== 1'b1) begin nerr++; $display("FAIL start_ready_i: got %b want 1", rdy_after); end
    wait_done();
    check_stream("eta2");
    nchk++;
    if (got[got_base] !== 23'd2 || got[got_base+1] !== 23'd1 || got[got_base+2] !== 23'd0 || got[got_base+3] !== QM - 1) begin
      nerr++; $display("FAIL eta2_beat0: got %0d %0d %0d %0d want 2 1 0 %0d", got[got_base], got[got_base+1],
                       got[got_base+2], got[got_base+3], QM - 1);
    end
    nchk++;
    if (got[got_base+4] !== QM - 2 || got[got_base+5] !== 23'd2 || got[got_base+14] !== QM - 2 || got[got_base+15] !== exp_c[15]) begin
      nerr++; $display("FAIL eta2_reject15: got %0d %0d %0d want %0d 2 %0d", got[got_base+4], got[got_base+5],
                       got[got_base+14], QM - 2, QM - 2);
    end
    bad_set = 1'b0;
    for (int i = got_base; i < got.size(); i++)
      if (!(got[i] <= 2 || got[i] >= QM - 2)) bad_set = 1'b1;
    nchk++;
    if (bad_set !== 1'b0) begin nerr++; $display("FAIL eta2_range: got out-of-range value, want within 2 of 0 mod q"); end
    orw = '0;
    for (int i = 0; i < 8; i++) orw |= absorbed[i];
    for (int i = 9; i < 16; i++) orw |= absorbed[i];
    nchk++;
    if (orw !== '0 || absorbed[8] !== 64'h0000_0000_001F_0000 || absorbed[16] !== 64'h8000_0000_0000_0000) begin
      nerr++; $display("FAIL eta2_absorb: zeros-or %0h w8 %0h w16 %0h want 0 1f0000 8000000000000000", orw,
                       absorbed[8], absorbed[16]);
    end
    repeat (4) @(negedge clk);
    nchk++;
    if (done_cnt - done_base !== 1 || valid_o !== 1'b0) begin
      nerr++; $display("FAIL eta2_done_once: got %0d dones valid_o %b want 1 dones valid_o 0", done_cnt - done_base, valid_o);
    end
  endtask

  task automatic test_eta4();
    logic bad_set, seed_bad;
    for (int i = 0; i < 8; i++) tb_seed[i] = {$urandom, $urandom};
    build_exp(1'b1, 2);
    launch(1'b1, 16'd5, 3'd3, 2);
    nchk++;
    if (rst_k !== 1'b1 || src_ready !== 1'b0) begin
      nerr++; $display("FAIL krst_timing: rst_k %b src_ready %b want 1 0", rst_k, src_ready);
    end
    @(negedge clk);
    nchk++;
    if (rst_k !== 1'b0 || src_ready !== 1'b1) begin
      nerr++; $display("FAIL absorb_timing: rst_k %b src_ready %b want 0 1", rst_k, src_ready);
    end
    wait_done();
    check_stream("eta4");
    nchk++;
    if (got[got_base] !== 23'd4 || got[got_base+3] !== 23'd1 || got[got_base+4] !== 23'd0 ||
        got[got_base+7] !== QM - 3 || got[got_base+8] !== QM - 4) begin
      nerr++; $display("FAIL eta4_word0: got %0d %0d %0d %0d %0d want 4 1 0 %0d %0d", got[got_base], got[got_base+3],
                       got[got_base+4], got[got_base+7], got[got_base+8], QM - 3, QM - 4);
    end
    bad_set = 1'b0;
    for (int i = got_base; i < got.size(); i++)
      if (!(got[i] <= 4 || got[i] >= QM - 4)) bad_set = 1'b1;
    nchk++;
    if (bad_set !== 1'b0) begin nerr++; $display("FAIL eta4_range: got out-of-range value, want within 4 of 0 mod q"); end
    seed_bad = 1'b0;
    for (int i = 0; i < 8; i++) if (absorbed[i] !== tb_seed[i]) seed_bad = 1'b1;
    nchk++;
    if (seed_bad !== 1'b0 || absorbed[8] !== 64'h0000_0000_001F_0005) begin
      nerr++; $display("FAIL eta4_absorb: seed_bad %b w8 %0h want 0 1f0005", seed_bad, absorbed[8]);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    logic [SW*SMW-1:0] snap;
    int sv;
    sv = stall_viol;
    build_exp(1'b0, 3);
    launch(1'b1, 16'd2, 3'd2, 3);
    while (!valid_o && cyc < 500) begin @(negedge clk); cyc++; end
    rdy_hold = 1'b1;
    @(negedge clk);
    snap = samples;
    repeat (20) @(negedge clk);
    nchk++;
    if (dst_ready !== 1'b0 || valid_o !== 1'b1 || samples !== snap) begin
      nerr++; $display("FAIL bp_full: dst_ready %b valid_o %b samples %0h want 0 1 %0h", dst_ready, valid_o, samples, snap);
    end
    rdy_hold = 1'b0;
    rdy_rand = 1'b1;
    wait_done();
    rdy_rand = 1'b0;
    check_stream("bp");
    nchk++;
    if (stall_viol - sv !== 0) begin nerr++; $display("FAIL bp_hold: got %0d unstable stalls want 0", stall_viol - sv); end
  endtask

  task automatic test_resample();
    int rb;
    logic seed_bad;
    rb = ri_seen;
    build_exp(1'b0, 4);
    launch(1'b0, 16'd1, 3'd2, 4);
    nchk++;
    if (rdy_after !== 1'b0 || rst_k !== 1'b1) begin
      nerr++; $display("FAIL rs_accept: ready_i %b rst_k %b want 0 1", rdy_after, rst_k);
    end
    wait_done();
    check_stream("resample");
    seed_bad = 1'b0;
    for (int i = 0; i < 8; i++) if (absorbed[i] !== tb_seed[i]) seed_bad = 1'b1;
    nchk++;
    if (seed_bad !== 1'b0 || absorbed[8] !== 64'h0000_0000_001F_0001 || ri_seen - rb !== 0) begin
      nerr++; $display("FAIL rs_seed: seed_bad %b w8 %0h ready_i cycles %0d want 0 1f0001 0", seed_bad, absorbed[8], ri_seen - rb);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc = 0, db;
    for (int i = 0; i < 8; i++) tb_seed[i] = {$urandom, $urandom};
    launch(1'b1, 16'd0, 3'd2, 5);
    while (got.size() - got_base < 40 && cyc < 2000) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    #1;
    nchk++;
    if ({valid_o, ready_i, done, rst_k, src_ready, dst_ready} !== 6'b0 || samples !== '0 || din !== '0) begin
      nerr++; $display("FAIL mid_rst_outs: ctl %b samples %0h want 0", {valid_o, ready_i, done, rst_k, src_ready, dst_ready}, samples);
    end
    db = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    nchk++;
    if (done_cnt !== db || valid_o !== 1'b0) begin
      nerr++; $display("FAIL mid_rst_done: got %0d dones valid_o %b want 0 0", done_cnt - db, valid_o);
    end
    for (int i = 0; i < 8; i++) tb_seed[i] = {$urandom, $urandom};
    build_exp(1'b0, 6);
    launch(1'b1, 16'd0, 3'd2, 6);
    wait_done();
    check_stream("after_rst");
    repeat (3) @(negedge clk);
    nchk++;
    if (done_cnt - done_base !== 1) begin nerr++; $display("FAIL after_rst_done: got %0d want 1", done_cnt - done_base); end
  endtask

  task automatic test_kc_stall();
    int cyc = 0, asnap, kv;
    build_exp(1'b1, 7);
    launch(1'b1, 16'd9, 3'd3, 7);
    while (a_idx < 3 && cyc < 100) begin @(negedge clk); cyc++; end
    keccak_ctrl = 1'b0;
    asnap = a_idx;
    kv = kc0_viol;
    repeat (100) @(negedge clk);
    nchk++;
    if (a_idx !== asnap || kc0_viol !== kv || src_ready !== 1'b0) begin
      nerr++; $display("FAIL kc_stall: words %0d->%0d viol %0d src_ready %b want no progress", asnap, a_idx, kc0_viol - kv, src_ready);
    end
    keccak_ctrl = 1'b1;
    wait_done();
    check_stream("kc");
    nchk++;
    if (absorbed[8] !== 64'h0000_0000_001F_0009 || absorbed[16] !== 64'h8000_0000_0000_0000) begin
      nerr++; $display("FAIL kc_absorb: w8 %0h w16 %0h want 1f0009 8000000000000000", absorbed[8], absorbed[16]);
    end
  endtask

  initial begin
    test_reset();
    test_eta2_zero();
    test_eta4();
    test_backpressure();
    test_resample();
    test_reset_mid();
    test_kc_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
